// File: rtl/ram_loader.sv
// ram_loader: byte-stream programming front-end for the SAP-1 16-byte RAM.
// Loads DEPTH data bytes over a valid/ready stream into RAM through its
// prog_mode/address/din port, checks a trailing checksum byte, then reads
// every location back through dout/n_ce and checks the readback sum.
//
// Stream handshake: a byte moves on every rising edge where in_valid and
// in_ready are both 1. in_ready is registered and only ever 1 in LOAD and
// CSUM. The sender may raise in_valid at any time and must hold in_data
// stable while in_valid is 1 and the transfer has not happened. The loader
// never applies backpressure mid-byte: once in_ready is 1 it stays 1 until
// the checksum byte or a timeout ends the stream.
//
// Timing summary (all outputs registered):
//   - the first cycle of LOAD is an entry cycle with in_ready=0;
//   - a transfer in cycle N drives prog_mode/address/din during cycle N+1;
//   - VERIFY presents one address per cycle with n_ce=0 and samples dout in
//     that same cycle, then one CHECK cycle compares the two sums.
// DEPTH must equal 2**ADDR_W so the address pointer wraps back to 0 on its
// own after the last word.

module ram_loader #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_prog_mode,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_n_ce,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  IDLE_LIMIT = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CSUM     = 2'b01;
    localparam logic [1:0] ERR_READBACK = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CSUM   = 3'd2,
        S_VERIFY = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              prog_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              n_ce_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [1:0]        err_code_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] rsum_q;
    logic [CNT_W-1:0]  idle_q;

    logic              xfer;
    logic [ADDR_W-1:0] ptr_d;
    logic [DATA_W-1:0] sum_d;
    logic [DATA_W-1:0] rsum_d;
    logic [CNT_W-1:0]  idle_d;
    logic              idle_expired;

    // Next values of the datapath accumulators and the handshake decode.
    always_comb begin
        xfer         = in_valid && in_ready_q;
        ptr_d        = ptr_q + 1'b1;
        sum_d        = sum_q + in_data;
        rsum_d       = rsum_q + ram_dout;
        idle_d       = idle_q + 1'b1;
        idle_expired = (idle_q == IDLE_LIMIT);
    end

    // Sequencer: state, RAM port drive, status flags and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            prog_q     <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            n_ce_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            ptr_q      <= '0;
            sum_q      <= '0;
            rsum_q     <= '0;
            idle_q     <= '0;
        end else begin
            // A write pulse lasts exactly one cycle after its transfer.
            prog_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        // Entry cycle into LOAD: everything from the previous
                        // run is wiped; in_ready rises one cycle later.
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b0;
                        n_ce_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                        ptr_q      <= '0;
                        sum_q      <= '0;
                        rsum_q     <= '0;
                        idle_q     <= '0;
                    end
                end

                S_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        prog_q <= 1'b1;
                        addr_q <= ptr_q;
                        din_q  <= in_data;
                        sum_q  <= sum_d;
                        ptr_q  <= ptr_d;
                        idle_q <= '0;
                        // ptr_d wraps to 0 after the last word.
                        if (ptr_q == LAST_ADDR) begin
                            state_q <= S_CSUM;
                        end
                    end else if (idle_expired) begin
                        state_q    <= S_ERROR;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end else begin
                        idle_q <= idle_d;
                    end
                end

                S_CSUM: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        idle_q     <= '0;
                        if (in_data == sum_q) begin
                            // First read address goes out on the next cycle.
                            state_q <= S_VERIFY;
                            ptr_q   <= '0;
                            rsum_q  <= '0;
                            addr_q  <= '0;
                            n_ce_q  <= 1'b0;
                        end else begin
                            state_q    <= S_ERROR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_CSUM;
                        end
                    end else if (idle_expired) begin
                        state_q    <= S_ERROR;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end else begin
                        idle_q <= idle_d;
                    end
                end

                S_VERIFY: begin
                    // RAM read is combinational: dout belongs to addr_q now.
                    rsum_q <= rsum_d;
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= S_CHECK;
                        ptr_q   <= '0;
                        addr_q  <= '0;
                        n_ce_q  <= 1'b1;
                    end else begin
                        ptr_q  <= ptr_d;
                        addr_q <= ptr_d;
                    end
                end

                S_CHECK: begin
                    busy_q <= 1'b0;
                    if (rsum_q == sum_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_ERROR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_READBACK;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    n_ce_q     <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign ram_prog_mode = prog_q;
    assign ram_address   = addr_q;
    assign ram_din       = din_q;
    assign ram_n_ce      = n_ce_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader: a small RAM model on the loader's RAM port, a
// stream driver, a per-cycle reference model of the write/read port and
// directed scenarios with hand-computed expectations.
module tb_ram_loader;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ram_prog_mode;
    logic [3:0] ram_address;
    logic [7:0] ram_din;
    logic       ram_n_ce;
    logic [7:0] ram_dout;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    ram_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_prog_mode(ram_prog_mode), .ram_address(ram_address),
        .ram_din(ram_din), .ram_n_ce(ram_n_ce), .ram_dout(ram_dout),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SAP-1 RAM model: synchronous write, combinational read; corrupt flips a
    // bit of location 5 on the read path only.
    logic [7:0] mem [DEPTH];
    logic       corrupt;
    always @(posedge clk) if (ram_prog_mode) mem[ram_address] <= ram_din;
    assign ram_dout = ram_n_ce ? 8'h00 :
                      (mem[ram_address] ^ ((corrupt && ram_address == 4'd5) ? 8'h40 : 8'h00));

    // scoreboard counters
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: what the write and read ports must show each cycle,
    // derived from the sequence of accepted stream bytes.
    logic [7:0] exp_q[$];      // data bytes of the current run, in order
    logic [7:0] m_sum;
    logic [7:0] rd_sum;
    logic [1:0] exp_code;
    logic       loading = 1'b0;
    logic       prev_xfer = 1'b0;
    logic [7:0] prev_data;
    int         prev_idx;
    int         byte_cnt = 0;
    int         rd_left = 0;
    int         prog_cnt = 0;
    int         rd_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            loading   = 1'b0;
            prev_xfer = 1'b0;
            byte_cnt  = 0;
            rd_left   = 0;
        end else begin
            // write port: one pulse per data byte, one cycle after it moved
            check("prog_mode", 32'(ram_prog_mode), 32'(prev_xfer && prev_idx < DEPTH));
            if (prev_xfer && prev_idx < DEPTH) begin
                check("wr_addr", 32'(ram_address), 32'(prev_idx));
                check("wr_data", 32'(ram_din), 32'(prev_data));
                prog_cnt++;
            end
            // read port: DEPTH reads right after a good checksum
            check("n_ce", 32'(ram_n_ce), 32'(rd_left == 0));
            if (rd_left > 0) begin
                check("rd_addr", 32'(ram_address), 32'(DEPTH - rd_left));
                rd_sum = rd_sum + ram_dout;
                rd_cnt++;
                rd_left--;
                if (rd_left == 0) exp_code = (rd_sum == m_sum) ? 2'b00 : 2'b10;
            end
            if (!loading) check("in_ready_off", 32'(in_ready), 32'd0);
            // record this cycle's activity
            if (start && !loading && rd_left == 0) begin
                loading  = 1'b1;
                byte_cnt = 0;
                m_sum    = 8'h00;
                rd_sum   = 8'h00;
                prog_cnt = 0;
                rd_cnt   = 0;
                exp_code = 2'b00;
                exp_q.delete();
            end
            prev_xfer = in_valid && in_ready;
            prev_data = in_data;
            prev_idx  = byte_cnt;
            if (prev_xfer) begin
                if (byte_cnt < DEPTH) begin
                    m_sum = m_sum + in_data;
                    exp_q.push_back(in_data);
                end else begin
                    loading = 1'b0;
                    if (in_data == m_sum) rd_left = DEPTH;
                    else exp_code = 2'b01;
                end
                byte_cnt++;
            end
        end
    end

    // driver tasks (all called and returning at posedge + 1)
    int s_cyc;
    int end_cyc;

    task automatic do_start();
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 40) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout: in_ready never rose, got 0 expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // 0x01..0x10 with gap idle cycles between bytes, then the checksum byte.
    task automatic send_stream(input int gap, input logic [7:0] csum, input logic poke_start);
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'(i + 1));
            for (int g = 0; g < gap; g++) begin
                if (poke_start && i == 5) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        send_byte(csum);
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (done || error) break;
            n++;
            if (n > bound) begin
                n_vec++; n_err++;
                $display("FAIL end_timeout: done/error never rose, got 0 expected 1");
                break;
            end
        end
        end_cyc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic check_ram_1_to_16(input string tag);
        for (int i = 0; i < DEPTH; i++) check(tag, 32'(mem[i]), 32'(i + 1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; corrupt = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: idle for 10 cycles, even with in_valid held high
        in_valid = 1'b1; in_data = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outs", 32'({ram_n_ce, ram_prog_mode, in_ready, busy, done, error, err_code}),
                  32'(8'b1000_0000));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // 2: back-to-back load, good checksum 0x88
        do_start();
        send_stream(0, 8'h88, 1'b0);
        wait_end(80);
        check("b2b_latency", 32'(end_cyc - s_cyc), 32'd36);
        check("b2b_done", 32'({done, error, err_code, busy}), 32'(5'b10000));
        check("b2b_code_model", 32'(err_code), 32'(exp_code));
        check("b2b_prog_cycles", 32'(prog_cnt), 32'd16);
        check("b2b_reads", 32'(rd_cnt), 32'd16);
        check("b2b_model_sum", 32'(m_sum), 32'h88);
        check("b2b_queue", 32'(exp_q.size()), 32'd16);
        check_ram_1_to_16("b2b_ram");

        // 3: in_valid every other cycle, plus a start pulse mid-load
        do_start();
        send_stream(1, 8'h88, 1'b1);
        wait_end(80);
        check("tog_done", 32'({done, error, err_code, busy}), 32'(5'b10000));
        check("tog_code_model", 32'(err_code), 32'(exp_code));
        check("tog_prog_cycles", 32'(prog_cnt), 32'd16);
        for (int i = 0; i < DEPTH; i++) check("tog_ram_vs_queue", 32'(mem[i]), 32'(exp_q[i]));

        // 4: wrong checksum 0x87
        do_start();
        send_stream(0, 8'h87, 1'b0);
        wait_end(20);
        check("csum_err", 32'({done, error, err_code, busy}), 32'(5'b01010));
        check("csum_code_model", 32'(err_code), 32'(exp_code));
        check("csum_no_reads", 32'(rd_cnt), 32'd0);

        // 5: location 5 corrupted on the read path during VERIFY
        do_start();
        send_stream(0, 8'h88, 1'b0);
        corrupt = 1'b1;
        wait_end(40);
        corrupt = 1'b0;
        check("rb_err", 32'({done, error, err_code, busy}), 32'(5'b01100));
        check("rb_code_model", 32'(err_code), 32'(exp_code));

        // 6: stall after 3 bytes; error exactly after 8 idle cycles
        do_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("to_not_yet", 32'({error, busy}), 32'(2'b01));
        end
        @(negedge clk);
        check("to_err", 32'({done, error, err_code, busy}), 32'(5'b01110));
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 7: reset in the middle of LOAD, memory left intact
        do_start();
        send_byte(8'hA0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        in_valid = 1'b1; in_data = 8'hEE;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_outs", 32'({ram_n_ce, ram_prog_mode, in_ready, busy, done, error, err_code}),
              32'(8'b1000_0000));
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem0", 32'(mem[0]), 32'hA0);
        check("rst_mem2", 32'(mem[2]), 32'hA2);
        check("rst_mem3", 32'(mem[3]), 32'h04);
        check("rst_mem15", 32'(mem[15]), 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
